fp16_operand_deserializer: RTL and testbench
============================================

// Module: fp16_operand_deserializer
// PURPOSE
//  Bit-serial to parallel front end for the FP16 adder.
//  Uses a demux-style write: each accepted bit is steered to one bit index of
//  the operand register under control of a 4-bit counter.
//  Assembles two 16-bit half-precision operands (A then B) from a 1-bit stream.
//  Presents the pair to the adder datapath through a valid/ready handshake.
// PARAMETERS
//  WIDTH      16  operand width in bits; the counter is $clog2(WIDTH) bits wide
//  MSB_FIRST  1   1: first bit lands at index WIDTH-1; 0: first bit lands at index 0
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  s_valid    in   1      serial bit valid
//  s_ready    out  1      serial bit accepted when s_valid & s_ready
//  s_bit      in   1      serial data bit
//  s_first    in   1      marks the accepted bit as bit 0 of operand A (frame start)
//  out_valid  out  1      op_a/op_b hold a complete pair
//  out_ready  in   1      adder consumes the pair when out_valid & out_ready
//  op_a       out  WIDTH  operand A, bit-ordered per MSB_FIRST
//  op_b       out  WIDTH  operand B
//  frame_err  out  1      one-cycle pulse on a resync event
// BEHAVIOUR
//  - Reset (rst_n low, async): state=COL_A, idx=0, op_a=op_b=0, out_valid=0, frame_err=0.
//    No bit is accepted while rst_n is low.
//  - States:
//    - COL_A: s_ready=1. An accepted bit is written to op_a[pos], then idx++.
//      When idx==WIDTH-1 on accept: idx<=0 and go to COL_B.
//    - COL_B: s_ready=1. Same write into op_b.
//      When idx==WIDTH-1 on accept: idx<=0, go to HOLD, out_valid<=1.
//    - HOLD: s_ready=0, out_valid=1; op_a/op_b stay stable.
//      out_ready=1 -> next cycle state=COL_A, out_valid=0.
//  - Write position: pos = MSB_FIRST ? WIDTH-1-idx : idx. Only the addressed bit changes.
//  - Latency:
//    - out_valid rises on the clock edge after the 2*WIDTH-th accepted bit.
//    - Minimum period per pair is 2*WIDTH+1 cycles (one HOLD cycle).
//  - s_valid gaps: the counter and state freeze and the partial operand is retained.
//  - Resync (s_first=1 on an accepted bit, but not at COL_A with idx==0):
//    - Partial data is discarded; op_b is not cleared.
//    - The bit is written as bit 0 of A; idx<=1; state<=COL_A.
//    - frame_err=1 for exactly one cycle.
//  - s_first=1 at COL_A with idx==0 is a normal accept with no error.
//    s_first=0 there is also accepted, so framing is optional.
//  - s_first is ignored in HOLD, because there s_ready=0.
//  - op_a/op_b are defined only while out_valid=1.
//  - Reset mid-operation: an immediate return to the reset values; the partial frame is lost.
// STRUCTURE
//  - Shared header fp16_defs.vh: FP16_W=16, state encodings COL_A=2'd0, COL_B=2'd1, HOLD=2'd2.
//  - Sub-module bit_demux16 (combinational):
//    - Inputs are a 4-bit index, an enable and one data bit.
//    - Outputs are a 16-bit one-hot write-enable and a replicated data bit.
//    - Instantiated once and shared between op_a and op_b via a state select.
//  - Top level holds the FSM, the index counter, the operand registers and the handshake.
// TESTING
//  1. MSB_FIRST=1: stream 16'h3C00 then 16'hC000 with s_valid always high
//     -> out_valid rises 32 cycles after the first accept; op_a=3C00, op_b=C000.
//  2. Backpressure: hold out_ready=0 for 5 cycles in HOLD
//     -> s_ready=0, operands stable, no bit lost.
//     Then out_ready=1 -> COL_A the next cycle and the next pair is accepted cleanly.
//  3. s_valid toggles every other cycle while streaming 16'h7BFF / 16'h0001
//     -> correct pair; out_valid after 32 accepts, not 32 cycles.
//  4. Resync: send 7 bits of A, then s_first=1 with a new full pair 16'h4000 / 16'h4200
//     -> frame_err pulses once; op_a=4000, op_b=4200.
//  5. Drop rst_n for 1 cycle during COL_B (idx=9) -> all outputs 0, state COL_A.
//     Then a fresh pair 16'h3555 / 16'h8001 assembles correctly.
//  6. MSB_FIRST=0: stream bits LSB-first for 16'h3C00 / 16'hC000 -> same op_a/op_b as test 1.

Source files
------------

// File: rtl/fp16_operand_deserializer_pkg.sv
// Shared definitions for the FP16 operand deserializer: operand width and
// FSM state encoding.
package fp16_operand_deserializer_pkg;

    localparam int FP16_W = 16;

    typedef enum logic [1:0] {
        ST_COL_A = 2'd0,
        ST_COL_B = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/fp16_operand_deserializer_bit_demux16.sv
// Combinational bit demultiplexer: turns a bit index plus enable into a
// one-hot write-enable vector and replicates the data bit across the word,
// so the caller can do a masked single-bit update of any operand register.
module bit_demux16 #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] we,
    output logic [WIDTH-1:0] data
);

    // Decode the index into a one-hot enable and fan the data bit out
    always_comb begin
        we   = {WIDTH{1'b0}};
        data = {WIDTH{din}};
        if (en) begin
            we[idx] = 1'b1;
        end else begin
            we = {WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/fp16_operand_deserializer.sv
// Bit-serial to parallel front end for the FP16 adder. Collects operand A
// then operand B from a 1-bit stream, one bit per accepted beat, and hands
// the pair over through a valid/ready handshake. A bit flagged s_first in
// the middle of a frame restarts the frame at bit 0 of A and pulses
// frame_err for one cycle.
module fp16_operand_deserializer
    import fp16_operand_deserializer_pkg::*;
#(
    parameter int WIDTH     = FP16_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_bit,
    input  logic             s_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             frame_err
);

    localparam int              IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_e            state_r;
    logic [IDX_W-1:0]  idx_r;
    logic [WIDTH-1:0]  op_a_r;
    logic [WIDTH-1:0]  op_b_r;
    logic              out_valid_r;
    logic              s_ready_r;
    logic              frame_err_r;

    logic              accept_s;
    logic              resync_s;
    logic              sel_b_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [IDX_W-1:0]  pos_s;
    logic [WIDTH-1:0]  we_s;
    logic [WIDTH-1:0]  data_s;

    // Accept/resync decode and bit-position mapping for the shared demux
    always_comb begin
        accept_s = s_valid & s_ready_r;
        resync_s = 1'b0;
        wr_idx_s = idx_r;
        sel_b_s  = 1'b0;
        pos_s    = IDX_ZERO;
        // s_first at the very start of A is a normal accept, anywhere else it restarts
        if (accept_s && s_first && !((state_r == ST_COL_A) && (idx_r == IDX_ZERO))) begin
            resync_s = 1'b1;
        end else begin
            resync_s = 1'b0;
        end
        if (resync_s) begin
            wr_idx_s = IDX_ZERO;
            sel_b_s  = 1'b0;
        end else begin
            wr_idx_s = idx_r;
            sel_b_s  = (state_r == ST_COL_B);
        end
        if (MSB_FIRST) begin
            pos_s = LAST_IDX - wr_idx_s;
        end else begin
            pos_s = wr_idx_s;
        end
    end

    bit_demux16 #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_demux (
        .idx  (pos_s),
        .en   (accept_s),
        .din  (s_bit),
        .we   (we_s),
        .data (data_s)
    );

    // Collection FSM, index counter, operand registers and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_COL_A;
            idx_r       <= IDX_ZERO;
            op_a_r      <= {WIDTH{1'b0}};
            op_b_r      <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            s_ready_r   <= 1'b1;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= resync_s;
            if (accept_s) begin
                if (sel_b_s) begin
                    op_b_r <= (op_b_r & ~we_s) | (data_s & we_s);
                end else begin
                    op_a_r <= (op_a_r & ~we_s) | (data_s & we_s);
                end
            end
            case (state_r)
                ST_COL_A, ST_COL_B: begin
                    if (resync_s) begin
                        state_r <= ST_COL_A;
                        idx_r   <= IDX_ONE;
                    end else if (accept_s) begin
                        if (idx_r == LAST_IDX) begin
                            idx_r <= IDX_ZERO;
                            if (state_r == ST_COL_A) begin
                                state_r <= ST_COL_B;
                            end else begin
                                state_r     <= ST_HOLD;
                                out_valid_r <= 1'b1;
                                s_ready_r   <= 1'b0;
                            end
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_r     <= ST_COL_A;
                        out_valid_r <= 1'b0;
                        s_ready_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_COL_A;
                    idx_r       <= IDX_ZERO;
                    out_valid_r <= 1'b0;
                    s_ready_r   <= 1'b1;
                end
            endcase
        end
    end

    assign s_ready   = s_ready_r;
    assign out_valid = out_valid_r;
    assign op_a      = op_a_r;
    assign op_b      = op_b_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_fp16_operand_deserializer.sv
// Bench for fp16_operand_deserializer. Two instances run side by side on the
// same handshake: one MSB-first, one LSB-first, each fed the bit order that
// should reproduce the same operand words. Expected values come from the
// words the bench chose to send and from counting accepted bits.
module tb_fp16_operand_deserializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_first;
    logic        s_bit_m;
    logic        s_bit_l;
    logic        out_ready;
    logic        s_ready_m, s_ready_l;
    logic        out_valid_m, out_valid_l;
    logic        frame_err_m, frame_err_l;
    logic [15:0] op_a_m, op_b_m, op_a_l, op_b_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp16_operand_deserializer #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_m),
        .s_bit(s_bit_m), .s_first(s_first), .out_valid(out_valid_m),
        .out_ready(out_ready), .op_a(op_a_m), .op_b(op_b_m), .frame_err(frame_err_m)
    );

    fp16_operand_deserializer #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_l),
        .s_bit(s_bit_l), .s_first(s_first), .out_valid(out_valid_l),
        .out_ready(out_ready), .op_a(op_a_l), .op_b(op_b_l), .frame_err(frame_err_l)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic ev, input logic er, input logic efe);
        chk({tag, "_out_valid_msb"}, {15'd0, out_valid_m}, {15'd0, ev});
        chk({tag, "_out_valid_lsb"}, {15'd0, out_valid_l}, {15'd0, ev});
        chk({tag, "_s_ready_msb"},   {15'd0, s_ready_m},   {15'd0, er});
        chk({tag, "_s_ready_lsb"},   {15'd0, s_ready_l},   {15'd0, er});
        chk({tag, "_frame_err_msb"}, {15'd0, frame_err_m}, {15'd0, efe});
        chk({tag, "_frame_err_lsb"}, {15'd0, frame_err_l}, {15'd0, efe});
    endtask

    task automatic chk_ops(input string tag, input logic [15:0] ea, input logic [15:0] eb);
        chk({tag, "_op_a_msb"}, op_a_m, ea);
        chk({tag, "_op_b_msb"}, op_b_m, eb);
        chk({tag, "_op_a_lsb"}, op_a_l, ea);
        chk({tag, "_op_b_lsb"}, op_b_l, eb);
    endtask

    // One clock: drive at the falling edge, the DUT samples on the rising
    // edge, and the next falling edge is where outputs are observed.
    task automatic step(input logic v, input logic bm, input logic bl, input logic f);
        s_valid = v;
        s_bit_m = bm;
        s_bit_l = bl;
        s_first = f;
        @(negedge clk);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    // Stream the first nbits of the 32-bit frame {A, B}. gap_mode: 0 none,
    // 1 one idle cycle before every bit, 2 random idle cycles.
    task automatic send_stream(input string tag, input logic [15:0] a, input logic [15:0] b,
                               input int nbits, input logic f0, input logic exp_rs,
                               input int gap_mode);
        logic [15:0] w;
        int          j;
        int          idle;
        for (int k = 0; k < nbits; k++) begin
            idle = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(2, 0)) : 0;
            for (int g = 0; g < idle; g++) begin
                step(1'b0, rbit(), rbit(), rbit());
                chk_ctrl({tag, "_gap"}, 1'b0, 1'b1, 1'b0);
            end
            w = (k < 16) ? a : b;
            j = k % 16;
            step(1'b1, w[15 - j], w[j], (k == 0) ? f0 : 1'b0);
            chk_ctrl(tag, (k == 31), (k != 31), (k == 0) && exp_rs);
        end
    endtask

    // Stay in HOLD for nwait cycles with bits offered, then release the pair.
    task automatic hold_release(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                                input int nwait);
        chk_ops(tag, ea, eb);
        out_ready = 1'b0;
        for (int i = 0; i < nwait; i++) begin
            step(1'b1, rbit(), rbit(), rbit());
            chk_ctrl({tag, "_hold"}, 1'b1, 1'b0, 1'b0);
            chk_ops({tag, "_hold"}, ea, eb);
        end
        out_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_ctrl({tag, "_release"}, 1'b0, 1'b1, 1'b0);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_first   = 1'b0;
        s_bit_m   = 1'b0;
        s_bit_l   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_ctrl("reset", 1'b0, 1'b1, 1'b0);
        chk_ops("reset", 16'h0000, 16'h0000);
        rst_n = 1'b1;

        // Back-to-back pair, no gaps
        send_stream("t1", 16'h3C00, 16'hC000, 32, 1'b1, 1'b0, 0);
        hold_release("t1", 16'h3C00, 16'hC000, 0);

        // Backpressure for five cycles, then the next pair must be clean
        ra = 16'($urandom);
        rb = 16'($urandom);
        send_stream("t2", ra, rb, 32, 1'b1, 1'b0, 0);
        hold_release("t2", ra, rb, 5);

        // Valid toggling every other cycle
        send_stream("t3", 16'h7BFF, 16'h0001, 32, 1'b1, 1'b0, 1);
        hold_release("t3", 16'h7BFF, 16'h0001, 1);

        // Resync after 7 bits of A
        send_stream("t4p", 16'($urandom), 16'h0000, 7, 1'b1, 1'b0, 0);
        send_stream("t4", 16'h4000, 16'h4200, 32, 1'b1, 1'b1, 0);
        hold_release("t4", 16'h4000, 16'h4200, 0);

        // Resync while collecting B
        send_stream("t4bp", 16'($urandom), 16'($urandom), 20, 1'b0, 1'b0, 0);
        send_stream("t4b", 16'hABCD, 16'h1234, 32, 1'b1, 1'b1, 2);
        hold_release("t4b", 16'hABCD, 16'h1234, 2);

        // Asynchronous reset while collecting B at index 9
        send_stream("t5p", 16'($urandom), 16'($urandom), 25, 1'b1, 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_ctrl("t5_async", 1'b0, 1'b1, 1'b0);
        chk_ops("t5_async", 16'h0000, 16'h0000);
        s_valid = 1'b1;
        @(negedge clk);
        chk_ctrl("t5_held", 1'b0, 1'b1, 1'b0);
        chk_ops("t5_held", 16'h0000, 16'h0000);
        rst_n = 1'b1;
        send_stream("t5", 16'h3555, 16'h8001, 32, 1'b1, 1'b0, 0);
        hold_release("t5", 16'h3555, 16'h8001, 0);

        // Randomized pairs with random gaps, optional framing and backpressure
        for (int n = 0; n < 8; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            send_stream("rnd", ra, rb, 32, rbit(), 1'b0, 2);
            hold_release("rnd", ra, rb, int'($urandom_range(3, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
